turbo_enc_ctrl: RTL and testbench

Block-level sequencer for the LTE turbo encoder. On a start request it reads one code block from the interleaver output buffer, drives two constituent RSC encoders in lockstep (natural order and interleaved order), and handles the start pulse, data phase and 3-cycle trellis termination. It assembles the 12 tail bits and emits a single three-stream output (d0/d1/d2) per 36.212 §5.1.3.2.2. It sits between the interleaver buffer and the rate-matching stage.

---
 rtl/turbo_enc_ctrl.sv | 134 +++++++++++++
 tb/tb_turbo_enc_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/turbo_enc_ctrl.sv
// Block sequencer for the LTE turbo encoder: reads one code block, drives both
// constituent encoders in lockstep, captures trellis termination and emits d0/d1/d2.
module turbo_enc_ctrl #(
    parameter int unsigned K_SMALL = 1056,
    parameter int unsigned K_LARGE = 6144,
    parameter int unsigned ADDR_W  = 13
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              start,
    input  logic              k_sel,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              mem_sys,
    input  logic              mem_int,
    output logic              enc_start,
    output logic              enc_k,
    output logic              c1,
    output logic              c2,
    input  logic              z1,
    input  logic              z2,
    input  logic              e1_q1,
    input  logic              e1_q2,
    input  logic              e2_q1,
    input  logic              e2_q2,
    output logic              d0,
    output logic              d1,
    output logic              d2,
    output logic              out_valid
);

    typedef enum logic [1:0] {IDLE, DATA, TAIL, FLUSH} state_t;

    state_t            state;
    logic [ADDR_W-1:0] k_last;
    logic [1:0]        sub;
    logic              data_v;
    logic [11:0]       tail;

    // Buffer data lands one cycle after each read; forced to 0 outside the data phase.
    assign c1 = data_v & mem_sys;
    assign c2 = data_v & mem_int;

    always_ff @(posedge clk) begin
        if (aclr) begin
            state     <= IDLE;
            k_last    <= '0;
            sub       <= 2'd0;
            data_v    <= 1'b0;
            tail      <= 12'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            enc_start <= 1'b0;
            enc_k     <= 1'b0;
            d0        <= 1'b0;
            d1        <= 1'b0;
            d2        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            enc_start <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            d0        <= 1'b0;
            d1        <= 1'b0;
            d2        <= 1'b0;
            data_v    <= rd_en;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= DATA;
                        busy      <= 1'b1;
                        enc_start <= 1'b1;
                        enc_k     <= k_sel;
                        rd_en     <= 1'b1;
                        rd_addr   <= '0;
                        k_last    <= k_sel ? ADDR_W'(K_LARGE - 1) : ADDR_W'(K_SMALL - 1);
                    end
                end
                DATA: begin
                    if (rd_en) begin
                        if (rd_addr == k_last) begin
                            rd_en   <= 1'b0;
                            rd_addr <= '0;
                        end else begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                        end
                    end
                    if (data_v) begin
                        d0        <= c1;
                        d1        <= z1;
                        d2        <= z2;
                        out_valid <= 1'b1;
                        // Last data word: reads already stopped, so termination starts next.
                        if (!rd_en) begin
                            state <= TAIL;
                            sub   <= 2'd0;
                        end
                    end
                end
                TAIL: begin
                    tail <= {tail[7:0], e1_q1 ^ e1_q2, z1, e2_q1 ^ e2_q2, z2};
                    sub  <= sub + 2'd1;
                    if (sub == 2'd2) begin
                        state <= FLUSH;
                        sub   <= 2'd0;
                    end
                end
                FLUSH: begin
                    // tail[11:8], [7:4], [3:0] hold {x, z, x', z'} for steps K, K+1, K+2.
                    out_valid <= 1'b1;
                    case (sub)
                        2'd0:    {d0, d1, d2} <= {tail[11], tail[10], tail[7]};
                        2'd1:    {d0, d1, d2} <= {tail[6],  tail[3],  tail[2]};
                        2'd2:    {d0, d1, d2} <= {tail[9],  tail[8],  tail[5]};
                        default: {d0, d1, d2} <= {tail[4],  tail[1],  tail[0]};
                    endcase
                    sub <= sub + 2'd1;
                    if (sub == 2'd3) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        enc_k <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_turbo_enc_ctrl.sv
// Scoreboard bench for turbo_enc_ctrl with behavioural RSC encoders and buffer model.
module tb_turbo_enc_ctrl;

    localparam int ADDR_W  = 13;
    localparam int K_SMALL = 1056;
    localparam int K_LARGE = 6144;

    logic              clk = 1'b0;
    logic              aclr, start, k_sel;
    logic              busy, done, rd_en, enc_start, enc_k, c1, c2;
    logic [ADDR_W-1:0] rd_addr;
    logic              mem_sys = 1'b0, mem_int = 1'b0;
    logic              z1, z2, e1_q1, e1_q2, e2_q1, e2_q2;
    logic              d0, d1, d2, out_valid;

    always #5 clk = ~clk;

    turbo_enc_ctrl #(.K_SMALL(K_SMALL), .K_LARGE(K_LARGE), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .aclr(aclr), .start(start), .k_sel(k_sel),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .mem_sys(mem_sys), .mem_int(mem_int), .enc_start(enc_start), .enc_k(enc_k),
        .c1(c1), .c2(c2), .z1(z1), .z2(z2),
        .e1_q1(e1_q1), .e1_q2(e1_q2), .e2_q1(e2_q1), .e2_q2(e2_q2),
        .d0(d0), .d1(d1), .d2(d2), .out_valid(out_valid)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // RSC step, g0 = 1+D^2+D^3 feedback, g1 = 1+D+D^3: returns {next_state, x, z}.
    function automatic logic [4:0] rsc(input logic [2:0] st, input logic c, input logic term);
        logic a, x;
        x = term ? (st[1] ^ st[2]) : c;
        a = x ^ st[1] ^ st[2];
        return {st[1], st[0], a, x, a ^ st[0] ^ st[2]};
    endfunction

    // Buffer model: one-cycle read latency.
    bit sys_mem [K_LARGE];
    bit int_mem [K_LARGE];
    always @(posedge clk) begin
        if (rd_en && int'(rd_addr) < K_LARGE) begin
            mem_sys <= sys_mem[rd_addr];
            mem_int <= int_mem[rd_addr];
        end
    end

    // Constituent encoders: armed by enc_start, K data steps then 3 termination steps.
    logic [2:0] st1, st2;
    logic [4:0] r1, r2;
    int         e_cnt, e_k;
    bit         e_act;
    always_comb begin
        e_k = enc_k ? K_LARGE : K_SMALL;
        r1  = rsc(st1, c1, e_cnt >= e_k);
        r2  = rsc(st2, c2, e_cnt >= e_k);
        z1  = r1[0];
        z2  = r2[0];
    end
    assign e1_q1 = st1[1];
    assign e1_q2 = st1[2];
    assign e2_q1 = st2[1];
    assign e2_q2 = st2[2];

    always @(posedge clk) begin
        if (aclr) begin
            e_act <= 1'b0; e_cnt <= 0; st1 <= 3'd0; st2 <= 3'd0;
        end else if (enc_start) begin
            e_act <= 1'b1; e_cnt <= 0; st1 <= 3'd0; st2 <= 3'd0;
        end else if (e_act) begin
            st1   <= r1[4:2];
            st2   <= r2[4:2];
            e_cnt <= e_cnt + 1;
            if (e_cnt == e_k + 2) e_act <= 1'b0;
        end
    end

    // Scoreboard entries: {done, d0, d1, d2}.
    logic [3:0] sb [$];
    logic [3:0] exp_w;

    task automatic push_block(input int k);
        logic [2:0] s1, s2;
        logic [4:0] ra, rb;
        logic [2:0] tx1, tz1, tx2, tz2;
        s1 = 3'd0;
        s2 = 3'd0;
        for (int i = 0; i < k; i++) begin
            ra = rsc(s1, sys_mem[i], 1'b0);
            rb = rsc(s2, int_mem[i], 1'b0);
            s1 = ra[4:2];
            s2 = rb[4:2];
            sb.push_back({1'b0, logic'(sys_mem[i]), ra[0], rb[0]});
        end
        for (int j = 0; j < 3; j++) begin
            ra = rsc(s1, 1'b0, 1'b1);
            rb = rsc(s2, 1'b0, 1'b1);
            s1 = ra[4:2];
            s2 = rb[4:2];
            tx1[j] = ra[1]; tz1[j] = ra[0];
            tx2[j] = rb[1]; tz2[j] = rb[0];
        end
        sb.push_back({1'b0, tx1[0], tz1[0], tx1[1]});
        sb.push_back({1'b0, tz1[1], tx1[2], tz1[2]});
        sb.push_back({1'b0, tx2[0], tz2[0], tx2[1]});
        sb.push_back({1'b1, tz2[1], tx2[2], tz2[2]});
    endtask

    int exp_addr = 0;
    int rd_cnt   = 0;
    int es_cnt   = 0;

    always @(negedge clk) begin
        if (enc_start) begin
            es_cnt++;
            exp_addr = 0;
        end
        if (rd_en) begin
            check("rd_addr", int'(rd_addr), exp_addr);
            exp_addr++;
            rd_cnt++;
        end
        if (out_valid) begin
            check("sb_avail", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp_w = sb.pop_front();
                check("word", int'({done, d0, d1, d2}), int'(exp_w));
            end
        end else if (done) begin
            check("done_valid", int'(out_valid), 1);
        end
    end

    function automatic int outs();
        return int'({busy, done, rd_en, enc_start, enc_k, c1, c2, d0, d1, d2, out_valid, rd_addr});
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < K_LARGE; i++) begin
            sys_mem[i] = (mode == 2) ? bit'($urandom_range(0, 1)) : 1'b0;
            int_mem[i] = (mode == 2) ? bit'($urandom_range(0, 1)) : 1'b0;
        end
        if (mode == 1) sys_mem[0] = 1'b1;
    endtask

    task automatic run_block(input logic ks, input bit disturb);
        int k, busy_n, first_v, done_c, ek_err, c;
        k = ks ? K_LARGE : K_SMALL;
        push_block(k);
        es_cnt = 0; rd_cnt = 0;
        busy_n = 0; first_v = -1; done_c = -1; ek_err = 0; c = 0;
        k_sel = ks;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (done_c < 0 && c < k + 40) begin
            if (busy) busy_n++;
            if (busy && enc_k !== ks) ek_err++;
            if (out_valid && first_v < 0) first_v = c;
            if (done) done_c = c;
            if (disturb) begin
                start = (c == 300 || c == 301);
                k_sel = ks ^ c[4];
            end
            c++;
            @(negedge clk);
        end
        start = 1'b0;
        k_sel = ks;
        check("done_seen", int'(done_c >= 0), 1);
        check("first_valid", first_v, 2);
        check("done_latency", done_c - first_v, k + 6);
        check("busy_len", busy_n, k + 8);
        check("rd_count", rd_cnt, k);
        check("enc_start_cnt", es_cnt, 1);
        check("enc_k_hold", ek_err, 0);
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic run_b2b();
        int k, c, done_n, es1, es2;
        k = K_SMALL;
        push_block(k);
        push_block(k);
        es_cnt = 0; rd_cnt = 0;
        c = 0; done_n = 0; es1 = -1; es2 = -1;
        k_sel = 1'b0;
        start = 1'b1;
        @(negedge clk);
        while (done_n < 2 && c < 2 * k + 60) begin
            if (enc_start) begin
                if (es1 < 0) es1 = c;
                else es2 = c;
            end
            if (done) done_n++;
            if (done_n == 2) start = 1'b0;
            c++;
            @(negedge clk);
        end
        start = 1'b0;
        check("b2b_done_cnt", done_n, 2);
        check("b2b_first_es", es1, 0);
        check("b2b_gap", es2 - es1, k + 9);
        check("b2b_es_cnt", es_cnt, 2);
        check("b2b_rd_count", rd_cnt, 2 * k);
        check("b2b_sb_drained", sb.size(), 0);
    endtask

    task automatic run_abort();
        int nv, c, done_n;
        nv = 0; c = 0; done_n = 0;
        push_block(K_LARGE);
        k_sel = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (nv < 501 && c < 700) begin
            @(negedge clk);
            c++;
            if (out_valid) nv++;
        end
        check("abort_reached", nv, 501);
        #1;
        aclr = 1'b1;
        sb.delete();
        @(negedge clk);
        check("abort_outs", outs(), 0);
        aclr = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) done_n++;
        end
        check("abort_no_done", done_n, 0);
        check("abort_idle", int'(busy), 0);
    endtask

    initial begin
        aclr  = 1'b1;
        start = 1'b0;
        k_sel = 1'b0;
        fill(0);
        repeat (3) @(negedge clk);
        check("reset_outs", outs(), 0);

        // reset and start on the same edge: start must be dropped
        start = 1'b1;
        @(negedge clk);
        check("aclr_wins_busy", int'(busy), 0);
        aclr  = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("aclr_wins_idle", outs(), 0);

        fill(0); run_block(1'b0, 1'b0);
        fill(1); run_block(1'b0, 1'b0);
        fill(2); run_block(1'b0, 1'b0);
        fill(2); run_block(1'b1, 1'b0);
        fill(2); run_block(1'b0, 1'b1);
        fill(2); run_b2b();
        fill(2); run_abort();
        fill(2); run_block(1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
